// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// freezes earlier stages while waiting, and formats the returned load data.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_address,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_mbe,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic [XLEN-1:0] load_data_o,
    output logic            done_o,
    output logic            stall_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [3:0]      mbe_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;
    logic            write_reg;
    logic [XLEN-1:0] load_data_reg;

    logic            req;
    logic            misaligned;
    logic            accept;
    logic [1:0]      off;
    logic [3:0]      mbe_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_fmt;

    assign req = valid_i & (mem_read_i | mem_write_i);
    assign off = alu_out_i[1:0];

    // funct3[1:0]: 00 byte, 01 half, anything else treated as a full word
    assign misaligned = ((funct3_i[1:0] == 2'b01) && off[0]) ||
                        (funct3_i[1]              && (off != 2'b00));

    assign accept = (state_reg == IDLE) && req && !misaligned;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign mbe_next[gi] = (funct3_i[1:0] == 2'b00) ? (off == LANE) :
                                  (funct3_i[1:0] == 2'b01) ? (off[1] == LANE[1]) :
                                  1'b1;
        end
    endgenerate

    assign wdata_next = rs2_i << {off, 3'b000};

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        done_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_o    = 1'b1;
                dmem_read  = ~write_reg;
                dmem_write = write_reg;
                if (dmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdata_shifted = dmem_rdata >> {off_reg, 3'b000};

    always_comb begin
        load_fmt = dmem_rdata;
        case (funct3_reg)
            3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_fmt = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_fmt = {16'd0, rdata_shifted[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            mbe_reg       <= '0;
            funct3_reg    <= '0;
            off_reg       <= '0;
            write_reg     <= 1'b0;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg   <= {alu_out_i[XLEN-1:2], 2'b00};
                wdata_reg  <= wdata_next;
                mbe_reg    <= mbe_next;
                funct3_reg <= funct3_i;
                off_reg    <= off;
                write_reg  <= mem_write_i;
            end
            // Stores complete without touching the last load result
            if ((state_reg == ACCESS) && dmem_resp && !write_reg) begin
                load_data_reg <= load_fmt;
            end
        end
    end

    assign dmem_address = addr_reg;
    assign dmem_wdata   = wdata_reg;
    assign dmem_mbe     = mbe_reg;
    assign load_data_o  = load_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, back-to-back and reset cases.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i, rs2_i;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] load_data_o;
    logic        done_o, stall_o, misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .alu_out_i(alu_out_i), .rs2_i(rs2_i),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .load_data_o(load_data_o), .done_o(done_o), .stall_o(stall_o),
        .misalign_o(misalign_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and plays memory, answering on the resp_at-th access cycle.
    // Returns in the cycle where done_o is seen (or after the cycle budget).
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input logic rd, input logic wr,
                              input int resp_at, input logic [31:0] rdata,
                              output int stall_cnt, output int rd_cnt, output int wr_cnt,
                              output logic [31:0] cap_addr, output logic [31:0] cap_wdata,
                              output logic [3:0] cap_mbe, output logic timeout);
        int acc;
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; alu_out_i = addr; rs2_i = wd;
        #1;
        stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; acc = 0; timeout = 1'b1;
        cap_addr = '0; cap_wdata = '0; cap_mbe = '0;
        for (int c = 0; c < 20; c++) begin
            if (done_o) begin
                timeout = 1'b0;
                break;
            end
            if (stall_o) stall_cnt++;
            if (dmem_read || dmem_write) begin
                acc++;
                if (dmem_read) rd_cnt++;
                if (dmem_write) wr_cnt++;
                cap_addr = dmem_address; cap_wdata = dmem_wdata; cap_mbe = dmem_mbe;
                if (acc == resp_at) begin
                    dmem_resp = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            tick();
            dmem_resp = 1'b0;
            dmem_rdata = '0;
            #1;
        end
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'b000; alu_out_i = '0; rs2_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        dmem_resp = 1'b0; dmem_rdata = '0;
        tick(); tick();
        checks++;
        if ({dmem_read, dmem_write, done_o, stall_o, misalign_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {dmem_read, dmem_write, done_o, stall_o, misalign_o});
        end
        checks++;
        if (load_data_o !== 32'h0 || dmem_address !== 32'h0 || dmem_wdata !== 32'h0 || dmem_mbe !== 4'h0) begin
            failures++;
            $display("FAIL reset_regs got load=%h addr=%h wdata=%h mbe=%b want all zero",
                     load_data_o, dmem_address, dmem_wdata, dmem_mbe);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_lb();
        int sc, rc, wc; logic [31:0] ca, cw; logic [3:0] cm; logic to;
        run_access(32'h0000_1003, 32'h0, 3'b000, 1'b1, 1'b0, 3, 32'h80FF_FF11, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to) begin failures++; $display("FAIL lb_timeout done_o never seen"); end
        checks++;
        if (ca !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr got=%h want=00001000", ca); end
        checks++;
        if (sc != 4) begin failures++; $display("FAIL lb_stall_cycles got=%0d want=4", sc); end
        checks++;
        if (rc != 3 || wc != 0) begin failures++; $display("FAIL lb_req_cycles got rd=%0d wr=%0d want rd=3 wr=0", rc, wc); end
        checks++;
        if (load_data_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h want=ffffff80", load_data_o); end
        checks++;
        if (stall_o !== 1'b0 || dmem_read !== 1'b0) begin
            failures++; $display("FAIL lb_done_state got stall=%b rd=%b want 0 0", stall_o, dmem_read);
        end
        idle_inputs();
        tick();
        checks++;
        if (done_o !== 1'b0) begin failures++; $display("FAIL lb_done_pulse got=%b want=0", done_o); end
        $display("test_lb addr=%h data=%h stall=%0d", ca, load_data_o, sc);
    endtask

    task automatic test_sh();
        int sc, rc, wc; logic [31:0] ca, cw; logic [3:0] cm; logic to;
        run_access(32'h0000_2002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 1, 32'h1234_5678, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to) begin failures++; $display("FAIL sh_timeout done_o never seen"); end
        checks++;
        if (cm !== 4'b1100) begin failures++; $display("FAIL sh_mbe got=%b want=1100", cm); end
        checks++;
        if (cw !== 32'hABCD_0000) begin failures++; $display("FAIL sh_wdata got=%h want=abcd0000", cw); end
        checks++;
        if (ca !== 32'h0000_2000) begin failures++; $display("FAIL sh_addr got=%h want=00002000", ca); end
        checks++;
        if (wc != 1 || rc != 0 || sc != 2) begin
            failures++; $display("FAIL sh_timing got wr=%0d rd=%0d stall=%0d want 1 0 2", wc, rc, sc);
        end
        checks++;
        if (load_data_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL sh_load_kept got=%h want=ffffff80", load_data_o); end
        idle_inputs();
        tick();
        $display("test_sh mbe=%b wdata=%h", cm, cw);
    endtask

    task automatic test_sb_sw_lanes();
        int sc, rc, wc; logic [31:0] ca, cw; logic [3:0] cm; logic to;
        run_access(32'h0000_2101, 32'h0000_00EE, 3'b000, 1'b0, 1'b1, 1, 32'h0, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to || cm !== 4'b0010 || cw !== 32'h0000_EE00) begin
            failures++; $display("FAIL sb_lane got mbe=%b wdata=%h to=%b want 0010 0000ee00 0", cm, cw, to);
        end
        idle_inputs(); tick();
        // read and write both asserted: write wins
        run_access(32'h0000_2204, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b1, 2, 32'h0, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to || cm !== 4'b1111 || cw !== 32'hDEAD_BEEF || wc != 2 || rc != 0) begin
            failures++; $display("FAIL sw_write_wins got mbe=%b wdata=%h wr=%0d rd=%0d want 1111 deadbeef 2 0", cm, cw, wc, rc);
        end
        idle_inputs(); tick();
        $display("test_sb_sw_lanes done");
    endtask

    task automatic test_misalign();
        int rd_seen;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        funct3_i = 3'b010; alu_out_i = 32'h0000_3001;
        #1;
        checks++;
        if (misalign_o !== 1'b1 || stall_o !== 1'b0) begin
            failures++; $display("FAIL lw_misalign got mis=%b stall=%b want 1 0", misalign_o, stall_o);
        end
        rd_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (dmem_read || done_o || stall_o) rd_seen++;
        end
        checks++;
        if (rd_seen != 0) begin failures++; $display("FAIL lw_no_access got=%0d active cycles want=0", rd_seen); end
        funct3_i = 3'b101; alu_out_i = 32'h0000_3003;
        #1;
        checks++;
        if (misalign_o !== 1'b1) begin failures++; $display("FAIL lhu_misalign got=%b want=1", misalign_o); end
        funct3_i = 3'b001; alu_out_i = 32'h0000_3002;
        #1;
        checks++;
        if (misalign_o !== 1'b0 || stall_o !== 1'b1) begin
            failures++; $display("FAIL lh_aligned got mis=%b stall=%b want 0 1", misalign_o, stall_o);
        end
        idle_inputs();
        #1;
        tick();
        $display("test_misalign done");
    endtask

    task automatic test_spurious_resp();
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        checks++;
        if (done_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL idle_resp got done=%b stall=%b load=%h want 0 0 ffffff80", done_o, stall_o, load_data_o);
        end
        $display("test_spurious_resp done");
    endtask

    task automatic test_back_to_back();
        int sc, rc, wc; logic [31:0] ca, cw; logic [3:0] cm; logic to;
        run_access(32'h0000_4002, 32'h0, 3'b101, 1'b1, 1'b0, 1, 32'h8001_0000, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to || load_data_o !== 32'h0000_8001) begin
            failures++; $display("FAIL lhu_data got=%h to=%b want 00008001 0", load_data_o, to);
        end
        // next load presented while in DONE: ignored there, accepted from IDLE
        funct3_i = 3'b010; alu_out_i = 32'h0000_4008;
        #1;
        checks++;
        if (stall_o !== 1'b0 || dmem_read !== 1'b0) begin
            failures++; $display("FAIL b2b_done_ignores got stall=%b rd=%b want 0 0", stall_o, dmem_read);
        end
        tick();
        checks++;
        if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got stall=%b want=1", stall_o); end
        run_access(32'h0000_4008, 32'h0, 3'b010, 1'b1, 1'b0, 1, 32'h1234_5678, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to || sc != 2 || rc != 1 || load_data_o !== 32'h1234_5678 || ca !== 32'h0000_4008) begin
            failures++; $display("FAIL b2b_second got data=%h stall=%0d rd=%0d addr=%h to=%b want 12345678 2 1 00004008 0",
                                 load_data_o, sc, rc, ca, to);
        end
        idle_inputs(); tick();
        $display("test_back_to_back data=%h", load_data_o);
    endtask

    task automatic test_reset_in_access();
        int bad;
        int sc, rc, wc; logic [31:0] ca, cw; logic [3:0] cm; logic to;
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_out_i = 32'h0000_6000;
        tick();
        checks++;
        if (dmem_read !== 1'b1) begin failures++; $display("FAIL rst_pre_access got rd=%b want=1", dmem_read); end
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dmem_read !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'h0 || dmem_address !== 32'h0) begin
            failures++; $display("FAIL rst_async got rd=%b stall=%b load=%h addr=%h want 0 0 0 0",
                                 dmem_read, stall_o, load_data_o, dmem_address);
        end
        tick();
        rst = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            dmem_resp = 1'b0;
            #1;
            if (done_o || dmem_read || load_data_o !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_late_resp got=%0d bad cycles want=0", bad); end
        // request present at the first edge after reset release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_access(32'h0000_7000, 32'h0, 3'b000, 1'b1, 1'b0, 1, 32'h0000_007F, sc, rc, wc, ca, cw, cm, to);
        checks++;
        if (to || sc != 2 || load_data_o !== 32'h0000_007F) begin
            failures++; $display("FAIL rst_first_edge got stall=%0d load=%h to=%b want 2 0000007f 0", sc, load_data_o, to);
        end
        idle_inputs(); tick();
        $display("test_reset_in_access done");
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_sb_sw_lanes();
        test_misalign();
        test_spurious_resp();
        test_back_to_back();
        test_reset_in_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
